// File: rtl/ram_ddr_pkg.sv
// Shared types and derived sizes for the burst DDR simulation memory.
package ram_ddr_pkg;

    // Controller states; READ issues array reads, DRAIN empties the return path.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Return FIFO must absorb every read in flight plus the beat being held.
    function automatic int fifo_depth(input int rd_latency);
        return rd_latency + 2;
    endfunction

endpackage

// File: rtl/ram_ddr_rd_fifo.sv
// Synchronous first-word-fall-through FIFO with an occupancy count.
// The head entry is visible on pop_data whenever empty is low.
module ram_ddr_rd_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                       clka,
    input  logic                       rsta,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_push  = push && (cnt != CW'(DEPTH));
    assign do_pop   = pop && (cnt != '0);
    assign pop_data = store[rptr];
    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign count    = cnt;

    // Pointer and occupancy bookkeeping; reset flushes all entries.
    always_ff @(posedge clka) begin
        if (rsta) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= ptr_inc(wptr);
            if (do_pop)  rptr <= ptr_inc(rptr);
            if (do_push && !do_pop)      cnt <= cnt + CW'(1);
            else if (!do_push && do_pop) cnt <= cnt - CW'(1);
        end
    end

    // Entry storage; contents are only meaningful behind a valid count.
    always_ff @(posedge clka) begin
        if (do_push) store[wptr] <= push_data;
    end

endmodule

// File: rtl/ram_ddr_burst.sv
// Burst DDR stand-in: command channel selects a write or read burst, write
// beats land in the array with byte enables, read data returns through a
// latency pipeline into a credit-limited FWFT FIFO.
// Handshakes: a transfer happens on a rising clka edge where valid and ready
// are both high; ready never depends on the same channel's valid.
module ram_ddr_burst
    import ram_ddr_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_DEPTH  = 65536,
    parameter int RD_LATENCY = 2,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    clka,
    input  logic                    rsta,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_wr,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_last,
    output logic                    busy,
    output state_t                  dbg_state
);
    localparam int FIFO_DEPTH = fifo_depth(RD_LATENCY);
    localparam int STRB_W     = DATA_WIDTH / 8;
    localparam int FW         = DATA_WIDTH + 1;
    localparam int CW         = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic [LEN_WIDTH-1:0]  cnt;
    logic                  wr_beat;
    logic                  issue;
    logic                  credit_ok;
    logic [FW-1:0]         issue_word;
    logic                  push;
    logic [FW-1:0]         push_word;
    logic                  pop;
    logic [FW-1:0]         pop_word;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [CW-1:0]         fifo_count;
    int                    inflight;

    // Word addresses wrap at the array size, not at 2**ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
        return (a == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    assign wr_beat    = wr_valid && wr_ready;
    assign pop        = rd_valid && rd_ready;
    assign credit_ok  = (int'(fifo_count) + inflight) < FIFO_DEPTH;
    assign issue_word = {(cnt == len), mem[addr]};
    assign dbg_state  = state;

    // State register.
    always_ff @(posedge clka) begin
        if (rsta) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode; DRAIN exits as soon as the last beat is being taken.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (cmd_valid && cmd_ready) state_nxt = cmd_wr ? ST_WRITE : ST_READ;
            ST_WRITE: if (wr_beat && cnt == len) state_nxt = ST_IDLE;
            ST_READ:  if (issue && cnt == len) state_nxt = ST_DRAIN;
            ST_DRAIN: if (inflight == 0 &&
                          (fifo_empty || (fifo_count == CW'(1) && pop))) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State-derived outputs; everything is held off while reset is asserted.
    always_comb begin
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        issue     = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE:  begin cmd_ready = !rsta; busy = 1'b0; end
            ST_WRITE: wr_ready = !rsta;
            ST_READ:  issue = credit_ok && !rsta;
            default:  ;
        endcase
    end

    // Burst address and beat counter, loaded on the command handshake.
    always_ff @(posedge clka) begin
        if (rsta) begin
            addr <= '0;
            len  <= '0;
            cnt  <= '0;
        end else if (state == ST_IDLE) begin
            if (cmd_valid && cmd_ready) begin
                addr <= cmd_addr;
                len  <= cmd_len;
                cnt  <= '0;
            end
        end else if (wr_beat || issue) begin
            addr <= addr_inc(addr);
            cnt  <= cnt + LEN_WIDTH'(1);
        end
    end

    // Byte-enabled array write; the array itself is never reset.
    always_ff @(posedge clka) begin
        if (wr_beat) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) mem[addr][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    generate
        if (RD_LATENCY == 1) begin : g_direct
            assign push      = issue;
            assign push_word = issue_word;
            assign inflight  = 0;
        end else begin : g_pipe
            logic [RD_LATENCY-2:0] pv;
            logic [FW-1:0]         pw [RD_LATENCY-1];

            // Valid shift chain; reset drops every read still in flight.
            always_ff @(posedge clka) begin
                if (rsta) begin
                    pv <= '0;
                end else begin
                    pv[0] <= issue;
                    for (int i = 1; i < RD_LATENCY - 1; i++) pv[i] <= pv[i-1];
                end
            end

            // Data/last shift chain riding alongside the valid bits.
            always_ff @(posedge clka) begin
                pw[0] <= issue_word;
                for (int i = 1; i < RD_LATENCY - 1; i++) pw[i] <= pw[i-1];
            end

            assign push      = pv[RD_LATENCY-2];
            assign push_word = pw[RD_LATENCY-2];
            assign inflight  = $countones(pv);
        end
    endgenerate

    ram_ddr_rd_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_rd_fifo (
        .clka      (clka),
        .rsta      (rsta),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .pop_data  (pop_word),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign rd_valid = !fifo_empty;
    assign rd_data  = rd_valid ? pop_word[DATA_WIDTH-1:0] : '0;
    assign rd_last  = rd_valid && pop_word[DATA_WIDTH];

endmodule

// File: tb/tb_ram_ddr_burst.sv
// Directed plus randomized bench for ram_ddr_burst with a word-array model.
module tb_ram_ddr_burst;
    localparam int DW    = 64;
    localparam int AW    = 16;
    localparam int DEPTH = 65536;
    localparam int LAT   = 2;
    localparam int LW    = 8;
    localparam int SW    = DW / 8;

    logic          clka = 1'b0;
    logic          rsta = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_wr = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic [SW-1:0] wr_strb = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          busy;
    logic [1:0]    dbg_state;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [DW-1:0] model_mem [int];
    logic [DW-1:0] wd_q [$];
    logic [SW-1:0] ws_q [$];
    logic [DW-1:0] exp_q [$];

    ram_ddr_burst #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .MEM_DEPTH (DEPTH),
        .RD_LATENCY (LAT), .LEN_WIDTH (LW)
    ) u_dut (
        .clka (clka), .rsta (rsta),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_wr (cmd_wr),
        .cmd_addr (cmd_addr), .cmd_len (cmd_len),
        .wr_valid (wr_valid), .wr_ready (wr_ready), .wr_data (wr_data), .wr_strb (wr_strb),
        .rd_valid (rd_valid), .rd_ready (rd_ready), .rd_data (rd_data), .rd_last (rd_last),
        .busy (busy), .dbg_state (dbg_state)
    );

    // Clock generation.
    always #5 clka = ~clka;

    // Hard stop if the sequence ever wedges.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int next_addr(input int a);
        return (a + 1) % DEPTH;
    endfunction

    // Model write: strobed bytes replace the old word's bytes.
    function automatic void model_write(input int a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        logic [DW-1:0] w;
        w = model_mem.exists(a) ? model_mem[a] : '0;
        for (int b = 0; b < SW; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
        model_mem[a] = w;
    endfunction

    // Issue a command from a negedge; returns at the negedge of cycle T+1.
    task automatic send_cmd(input logic wr, input int addr, input int len);
        int n;
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = AW'(addr); cmd_len = LW'(len);
        n = 0;
        while (!cmd_ready && n < 200) begin @(negedge clka); n++; end
        chk("cmd_accept", 64'(cmd_ready), 64'(1));
        @(negedge clka);
        cmd_valid = 1'b0;
        chk("busy_after_cmd", 64'(busy), 64'(1));
    endtask

    // Push the beats in wd_q/ws_q; optionally confirm the command lockout.
    task automatic drive_write(input int addr, input int len, input bit gaps, input bit lock);
        int  a = addr;
        int  i = 0;
        int  guard = 0;
        bit  acc;
        while (i <= len && guard < 2000) begin
            wr_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            wr_data  = wd_q[i];
            wr_strb  = ws_q[i];
            chk("wr_ready_in_burst", 64'(wr_ready), 64'(1));
            if (lock) chk("lockout_cmd_ready", 64'(cmd_ready), 64'(0));
            acc = wr_valid && wr_ready;
            @(negedge clka);
            guard++;
            if (acc) begin
                model_write(a, wd_q[i], ws_q[i]);
                a = next_addr(a);
                i++;
            end
        end
        wr_valid = 1'b0;
        chk("write_beats_done", 64'(i), 64'(len + 1));
        chk("cmd_ready_after_write", 64'(cmd_ready), 64'(1));
    endtask

    task automatic write_burst(input int addr, input int len, input bit gaps);
        send_cmd(1'b1, addr, len);
        drive_write(addr, len, gaps, 1'b0);
    endtask

    // Collect a read burst (entered at cycle T+1). mode 0: ready high,
    // 1: random 1-in-3, 2: fixed 1-in-3. stop>=0 ends after that many beats.
    task automatic collect_read(input int addr, input int len, input int mode,
                                input bit chk_lat, input int stop);
        int            a = addr;
        int            idx = 0;
        int            guard = 0;
        bit            acc;
        bit            stalled = 0;
        logic [DW-1:0] held_d = '0;
        logic          held_l = 1'b0;
        exp_q.delete();
        for (int k = 0; k <= len; k++) begin
            exp_q.push_back(model_mem[a]);
            a = next_addr(a);
        end
        if (chk_lat) begin
            rd_ready = 1'b0;
            for (int k = 0; k < LAT; k++) begin
                chk("rd_valid_early", 64'(rd_valid), 64'(0));
                @(negedge clka);
            end
            chk("first_rd_valid", 64'(rd_valid), 64'(1));
        end
        while (idx <= len && guard < 3000 && !(stop >= 0 && idx == stop)) begin
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = ($urandom_range(0, 2) == 0);
                default: rd_ready = (guard % 3 == 0);
            endcase
            if (stalled) begin
                chk("rd_valid_hold", 64'(rd_valid), 64'(1));
                chk("rd_data_hold", rd_data, held_d);
                chk("rd_last_hold", 64'(rd_last), 64'(held_l));
            end
            if (rd_valid) begin
                chk("rd_data", rd_data, exp_q[0]);
                chk("rd_last", 64'(rd_last), 64'(idx == len));
                acc     = rd_ready;
                stalled = !rd_ready;
                held_d  = rd_data;
                held_l  = rd_last;
            end else begin
                acc     = 1'b0;
                stalled = 1'b0;
            end
            @(negedge clka);
            guard++;
            if (acc) begin
                void'(exp_q.pop_front());
                idx++;
            end
        end
        rd_ready = 1'b0;
        if (stop < 0) begin
            chk("read_beats_done", 64'(idx), 64'(len + 1));
            chk("rd_no_extra", 64'(rd_valid), 64'(0));
            chk("cmd_ready_after_read", 64'(cmd_ready), 64'(1));
            chk("idle_after_read", 64'(busy), 64'(0));
        end
    endtask

    task automatic read_burst(input int addr, input int len, input int mode, input bit chk_lat);
        send_cmd(1'b0, addr, len);
        collect_read(addr, len, mode, chk_lat, -1);
    endtask

    task automatic fill_full(input int len);
        wd_q.delete(); ws_q.delete();
        for (int k = 0; k <= len; k++) begin
            wd_q.push_back({$urandom(), $urandom()});
            ws_q.push_back('1);
        end
    endtask

    // Directed sequence followed by randomized bursts.
    initial begin
        int base;
        int len;

        // Reset behaviour.
        repeat (3) @(negedge clka);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("rst_wr_ready", 64'(wr_ready), 64'(0));
        chk("rst_rd_valid", 64'(rd_valid), 64'(0));
        chk("rst_rd_last", 64'(rd_last), 64'(0));
        chk("rst_rd_data", rd_data, 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        rsta = 1'b0;
        #1;
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));
        @(negedge clka);

        // Write then read back with latency check.
        wd_q = '{64'h11, 64'h22, 64'h33, 64'h44};
        ws_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        write_burst(16'h0010, 3, 1'b0);
        read_burst(16'h0010, 3, 0, 1'b1);

        // Byte enables.
        wd_q = '{64'hFFFF_FFFF_FFFF_FFFF}; ws_q = '{8'hFF};
        write_burst(5, 0, 1'b0);
        wd_q = '{64'h0}; ws_q = '{8'h0F};
        write_burst(5, 0, 1'b0);
        read_burst(5, 0, 0, 1'b1);

        // Address wrap.
        fill_full(3);
        write_burst(DEPTH - 2, 3, 1'b0);
        read_burst(DEPTH - 2, 3, 0, 1'b1);

        // Back-pressure at a fixed 1-in-3 duty.
        fill_full(15);
        write_burst(16'h0100, 15, 1'b1);
        read_burst(16'h0100, 15, 2, 1'b0);

        // Reset part way through a read burst.
        send_cmd(1'b0, 16'h0100, 7);
        collect_read(16'h0100, 7, 0, 1'b0, 2);
        rsta = 1'b1;
        #1;
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'(0));
        @(negedge clka);
        rsta = 1'b0;
        #1;
        chk("after_rst_rd_valid", 64'(rd_valid), 64'(0));
        chk("after_rst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("after_rst_busy", 64'(busy), 64'(0));
        for (int k = 0; k < 4; k++) begin
            @(negedge clka);
            chk("no_stale_rd_valid", 64'(rd_valid), 64'(0));
        end
        read_burst(16'h0100, 7, 0, 1'b1);

        // Busy lockout: second command held valid through a write burst.
        fill_full(3);
        send_cmd(1'b1, 16'h0200, 3);
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'h0200; cmd_len = 8'd3;
        drive_write(16'h0200, 3, 1'b1, 1'b1);
        @(negedge clka);
        cmd_valid = 1'b0;
        chk("second_cmd_taken", 64'(busy), 64'(1));
        collect_read(16'h0200, 3, 0, 1'b1, -1);

        // Randomized bursts: full write, strobed overwrite, stalled read.
        for (int it = 0; it < 6; it++) begin
            base = $urandom_range(0, DEPTH - 1);
            len  = $urandom_range(0, 15);
            fill_full(len);
            write_burst(base, len, 1'b1);
            wd_q.delete(); ws_q.delete();
            for (int k = 0; k <= len; k++) begin
                wd_q.push_back({$urandom(), $urandom()});
                ws_q.push_back(SW'($urandom_range(0, 255)));
            end
            write_burst(base, len, 1'b1);
            read_burst(base, len, 1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
